dma_bus_master: RTL and testbench

Bus-master cycle generator for the SDMAC replacement: the initiator side of the 68030 bus protocol that the CPU-slave/register path answers. On request from the DMA engine it arbitrates for the bus (_BR/_BG/_BGACK), enables Ramsey's address generator (_DMAEN), and runs 32-bit memory read/write cycles terminated by _STERM, _DSACK or _BERR. It then releases the bus. Pad tri-stating stays in main_top; this block supplies values plus output enables.

---
 rtl/sdmac_pkg.sv | 28 ++
 rtl/dma_arbiter.sv | 67 ++++++
 rtl/dma_bus_master.sv | 144 ++++++++++++++
 tb/tb_dma_bus_master.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sdmac_pkg.sv
// Shared types and constants for the SDMAC bus-master path.
package sdmac_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_OWN,
    ARB_TENURE,
    ARB_REL
  } arb_state_e;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_START,
    SEQ_WAIT,
    SEQ_TERM,
    SEQ_RECOV
  } seq_state_e;

  localparam logic       SIZ_LONG = 1'b0;
  localparam logic [1:0] DSACK_32 = 2'b00;

  // A 8/16-bit port answer on a 32-bit master cycle cannot be resized here.
  function automatic logic dsack_narrow(input logic [1:0] i_dsack);
    return (i_dsack == 2'b01) || (i_dsack == 2'b10);
  endfunction

endpackage

// File: rtl/dma_arbiter.sv
// 68030 bus arbitration handshake: request, qualified grant, tenure, release.
module dma_arbiter
  import sdmac_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_bg_n,
  input  logic i_as_n,
  input  logic i_bgack_n,
  input  logic i_release,
  output logic o_granted,
  output logic o_br_n,
  output logic o_bgack_n,
  output logic o_bus_oe,
  output logic o_dmaen_n
);

  arb_state_e r_state;
  logic       r_br_n, r_bgack_n, r_bus_oe, r_dmaen_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_br_n    <= 1'b1;
      r_bgack_n <= 1'b1;
      r_bus_oe  <= 1'b0;
      r_dmaen_n <= 1'b1;
    end else begin
      case (r_state)
        ARB_IDLE: if (i_req) begin
          r_state <= ARB_REQ;
          r_br_n  <= 1'b0;
        end
        ARB_REQ: begin
          if (!i_req) begin
            r_state <= ARB_IDLE;
            r_br_n  <= 1'b1;
          end else if (!i_bg_n && i_as_n && i_bgack_n) begin
            // Grant only counts once the previous master has left the bus.
            r_state   <= ARB_OWN;
            r_br_n    <= 1'b1;
            r_bgack_n <= 1'b0;
            r_bus_oe  <= 1'b1;
            r_dmaen_n <= 1'b0;
          end
        end
        ARB_OWN:    r_state <= ARB_TENURE;
        ARB_TENURE: if (i_release) begin
          r_state   <= ARB_REL;
          r_bgack_n <= 1'b1;
          r_bus_oe  <= 1'b0;
          r_dmaen_n <= 1'b1;
        end
        ARB_REL:    r_state <= ARB_IDLE;
        default:    r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_granted = (r_state == ARB_OWN);
  assign o_br_n    = r_br_n;
  assign o_bgack_n = r_bgack_n;
  assign o_bus_oe  = r_bus_oe;
  assign o_dmaen_n = r_dmaen_n;

endmodule

// File: rtl/dma_bus_master.sv
// Bus-master cycle generator: arbitrates for the 68030 bus and runs 32-bit
// read/write beats terminated by _STERM, _DSACK, _BERR or timeout.
module dma_bus_master
  import sdmac_pkg::*;
#(
  parameter int BURST_MAX = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        SCLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        LAST,
  input  logic        WR,
  input  logic [31:0] WDATA,
  output logic        ACK,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        _BR,
  input  logic        _BG,
  output logic        _BGACK_O,
  input  logic        _BGACK_I,
  input  logic        _AS_I,
  output logic        _AS_O,
  output logic        _DS_O,
  output logic        R_W_O,
  output logic        SIZ1_O,
  output logic        BUS_OE,
  output logic        DATA_OE,
  output logic [31:0] DATA_O,
  output logic        _DMAEN,
  input  logic        _STERM,
  input  logic [1:0]  _DSACK,
  input  logic        _BERR,
  input  logic [31:0] DATA_IN
);

  localparam int BW = $clog2(BURST_MAX + 1);

  seq_state_e    r_state;
  logic [BW-1:0] r_beats;
  logic [7:0]    r_tmo;
  logic          r_wr, r_err_last, r_as_n, r_ds_n, r_rw, r_data_oe, r_ack, r_err;
  logic [31:0]   r_rdata, r_wdata;

  logic          w_granted, w_more, w_release, w_go_start;
  logic          w_fault, w_done, w_ok, w_tmo_hit, w_term;
  logic [7:0]    w_tmo_inc;

  // Priority _BERR > _STERM > _DSACK; a narrow DSACK is only a fault if _STERM is idle.
  assign w_fault   = !_BERR || (_STERM && dsack_narrow(_DSACK));
  assign w_done    = !_STERM || (_DSACK == DSACK_32);
  assign w_ok      = _BERR && w_done;
  assign w_tmo_inc = r_tmo + 8'd1;
  assign w_tmo_hit = (w_tmo_inc == 8'(TIMEOUT));
  assign w_term    = w_fault || w_done || w_tmo_hit;

  assign w_more     = !r_err_last && REQ && !LAST && (r_beats < BW'(BURST_MAX));
  assign w_release  = (r_state == SEQ_RECOV) && !w_more;
  assign w_go_start = ((r_state == SEQ_IDLE) && w_granted) ||
                      ((r_state == SEQ_RECOV) && w_more);

  dma_arbiter u_arb (
    .clk       (SCLK),
    .rst       (RST),
    .i_req     (REQ),
    .i_bg_n    (_BG),
    .i_as_n    (_AS_I),
    .i_bgack_n (_BGACK_I),
    .i_release (w_release),
    .o_granted (w_granted),
    .o_br_n    (_BR),
    .o_bgack_n (_BGACK_O),
    .o_bus_oe  (BUS_OE),
    .o_dmaen_n (_DMAEN)
  );

  always_ff @(posedge SCLK) begin
    if (RST) begin
      r_state    <= SEQ_IDLE;
      r_beats    <= '0;
      r_tmo      <= '0;
      r_wr       <= 1'b0;
      r_err_last <= 1'b0;
      r_as_n     <= 1'b1;
      r_ds_n     <= 1'b1;
      r_rw       <= 1'b1;
      r_data_oe  <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_wdata    <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        SEQ_IDLE:  ;
        SEQ_START: r_state <= SEQ_WAIT;
        SEQ_WAIT: begin
          r_tmo <= w_tmo_hit ? 8'(TIMEOUT) : w_tmo_inc;
          if (w_term) begin
            r_state    <= SEQ_TERM;
            r_as_n     <= 1'b1;
            r_ds_n     <= 1'b1;
            r_data_oe  <= 1'b0;
            r_beats    <= r_beats + BW'(1);
            r_ack      <= w_ok;
            r_err      <= !w_ok;
            r_err_last <= !w_ok;
            if (w_ok && !r_wr) r_rdata <= DATA_IN;
          end
        end
        SEQ_TERM:  r_state <= SEQ_RECOV;
        SEQ_RECOV: if (!w_more) begin
          r_state <= SEQ_IDLE;
          r_beats <= '0;
        end
        default:   r_state <= SEQ_IDLE;
      endcase
      // Beat launch overrides the case above: entry from a fresh grant or a burst continue.
      if (w_go_start) begin
        r_state    <= SEQ_START;
        r_wr       <= WR;
        r_wdata    <= WDATA;
        r_rw       <= !WR;
        r_data_oe  <= WR;
        r_as_n     <= 1'b0;
        r_ds_n     <= 1'b0;
        r_tmo      <= '0;
        r_err_last <= 1'b0;
      end
    end
  end

  assign ACK     = r_ack;
  assign ERR     = r_err;
  assign RDATA   = r_rdata;
  assign _AS_O   = r_as_n;
  assign _DS_O   = r_ds_n;
  assign R_W_O   = r_rw;
  assign SIZ1_O  = SIZ_LONG;
  assign DATA_OE = r_data_oe;
  assign DATA_O  = r_wdata;

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master: bus/arbiter responder, response scoreboard,
// table of single-beat tenures plus burst, arbitration and reset sequences.
module tb_dma_bus_master;

  localparam int BURST_MAX = 8;
  localparam int TIMEOUT   = 255;
  localparam int T_NONE = 0, T_STERM = 1, T_DS32 = 2, T_BERR = 3, T_DS01 = 4;

  logic        SCLK = 1'b0, RST = 1'b1, REQ = 1'b0, LAST = 1'b0, WR = 1'b0;
  logic [31:0] WDATA = '0, DATA_IN = '0;
  logic        ACK, ERR, _BR, _BGACK_O, _BGACK_I, _AS_I, _AS_O, _DS_O, R_W_O, SIZ1_O;
  logic        BUS_OE, DATA_OE, _DMAEN;
  logic [31:0] RDATA, DATA_O;
  logic        _BG = 1'b1, _STERM = 1'b1, _BERR = 1'b1;
  logic [1:0]  _DSACK = 2'b11;

  int n_vec = 0, n_bad = 0;
  int cfg_gdelay = 1, cfg_term = T_NONE, cfg_wait = 0;
  bit as_busy = 1'b0;
  int br_cnt = 0, as_cnt = 0, as_len = 0, oe_cnt = 0, oe_len = 0;
  logic rw_seen = 1'b1;

  typedef struct packed { logic err; logic [31:0] rdata; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic wr; logic [31:0] wdata; logic [31:0] din;
    int gdelay; int term; int waitc; logic last;
    logic exp_err; logic [31:0] exp_rdata; int exp_len;
  } vec_t;
  vec_t vt[7];

  dma_bus_master #(.BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT)) dut (
    .SCLK(SCLK), .RST(RST), .REQ(REQ), .LAST(LAST), .WR(WR), .WDATA(WDATA),
    .ACK(ACK), .ERR(ERR), .RDATA(RDATA), ._BR(_BR), ._BG(_BG),
    ._BGACK_O(_BGACK_O), ._BGACK_I(_BGACK_I), ._AS_I(_AS_I), ._AS_O(_AS_O),
    ._DS_O(_DS_O), .R_W_O(R_W_O), .SIZ1_O(SIZ1_O), .BUS_OE(BUS_OE),
    .DATA_OE(DATA_OE), .DATA_O(DATA_O), ._DMAEN(_DMAEN), ._STERM(_STERM),
    ._DSACK(_DSACK), ._BERR(_BERR), .DATA_IN(DATA_IN)
  );

  always #5 SCLK = ~SCLK;

  // Pads as seen by the board: our own drive when enabled, otherwise pulled up.
  assign _AS_I    = as_busy ? 1'b0 : (BUS_OE ? _AS_O : 1'b1);
  assign _BGACK_I = BUS_OE ? _BGACK_O : 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Arbiter and memory slave model.
  always @(negedge SCLK) begin
    br_cnt = _BR ? 0 : br_cnt + 1;
    _BG = !(!_BR && br_cnt >= cfg_gdelay);
    if (!_AS_O) begin
      as_cnt++;
      if (DATA_OE) oe_cnt++;
      rw_seen = R_W_O;
    end else if (as_cnt != 0) begin
      as_len = as_cnt; oe_len = oe_cnt; as_cnt = 0; oe_cnt = 0;
    end
    _STERM = 1'b1; _BERR = 1'b1; _DSACK = 2'b11;
    if (as_cnt != 0 && as_cnt == cfg_wait + 2) begin
      case (cfg_term)
        T_STERM: _STERM = 1'b0;
        T_DS32:  _DSACK = 2'b00;
        T_BERR:  _BERR  = 1'b0;
        T_DS01:  _DSACK = 2'b01;
        default: ;
      endcase
    end
  end

  // Scoreboard: every ACK/ERR pulse must match the next expected response.
  always @(negedge SCLK) begin
    exp_t e;
    if (ACK || ERR) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b, required no response", ACK, ERR);
      end else begin
        e = sb.pop_front();
        chk("resp_ack", 32'(ACK), 32'(!e.err));
        chk("resp_err", 32'(ERR), 32'(e.err));
        chk("resp_rdata", RDATA, e.rdata);
      end
    end
  end

  task automatic wait_resp(input string nm);
    int n = 0;
    while (!(ACK || ERR) && n < 400) begin @(negedge SCLK); n++; end
    chk(nm, 32'(ACK || ERR), 32'd1);
  endtask

  task automatic wait_rel(output int n);
    n = 0;
    do begin @(negedge SCLK); n++; end while (BUS_OE && n < 50);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, 32'({_BR, _BGACK_O, _AS_O, _DS_O, R_W_O, SIZ1_O, BUS_OE,
                          DATA_OE, _DMAEN, ACK, ERR}), 32'(11'b11111000100));
    chk({nm, "_rdata"}, RDATA, 32'd0);
  endtask

  initial begin
    int n, cyc, nack, last_ack;
    bit owned, rel, saw_br;
    //       wr    wdata         din           gd term     wt last err  rdata         len
    vt[0] = '{1'b0, 32'h0,        32'hDEADBEEF, 3, T_STERM, 0, 1'b1, 1'b0, 32'hDEADBEEF, 2};
    vt[1] = '{1'b1, 32'h12345678, 32'h0BAD0BAD, 1, T_DS32,  2, 1'b1, 1'b0, 32'hDEADBEEF, 4};
    vt[2] = '{1'b0, 32'h0,        32'hA5A50F0F, 2, T_DS32,  1, 1'b1, 1'b0, 32'hA5A50F0F, 3};
    vt[3] = '{1'b0, 32'h0,        32'hFFFF0000, 1, T_BERR,  0, 1'b0, 1'b1, 32'hA5A50F0F, 2};
    vt[4] = '{1'b1, 32'hCAFEF00D, 32'h11111111, 1, T_DS01,  1, 1'b1, 1'b1, 32'hA5A50F0F, 3};
    vt[5] = '{1'b0, 32'h0,        32'h22222222, 1, T_NONE,  0, 1'b1, 1'b1, 32'hA5A50F0F, 256};
    vt[6] = '{1'b0, 32'h0,        32'h00000001, 1, T_STERM, 3, 1'b1, 1'b0, 32'h00000001, 5};

    repeat (3) @(negedge SCLK);
    chk_reset("reset");
    RST = 1'b0;
    @(negedge SCLK);

    for (int i = 0; i < 7; i++) begin
      cfg_gdelay = vt[i].gdelay; cfg_term = vt[i].term; cfg_wait = vt[i].waitc;
      DATA_IN = vt[i].din;
      sb.push_back('{vt[i].exp_err, vt[i].exp_rdata});
      REQ = 1'b1; LAST = vt[i].last; WR = vt[i].wr; WDATA = vt[i].wdata;
      wait_resp($sformatf("v%0d_resp_seen", i));
      if (vt[i].last) REQ = 1'b0;
      wait_rel(n);
      REQ = 1'b0;
      chk($sformatf("v%0d_release_delay", i), n, 2);
      repeat (3) @(negedge SCLK);
      chk($sformatf("v%0d_beat_len", i), as_len, vt[i].exp_len);
      chk($sformatf("v%0d_data_oe_cycles", i), oe_len, vt[i].wr ? vt[i].exp_len : 0);
      chk($sformatf("v%0d_r_w", i), 32'(rw_seen), 32'(!vt[i].wr));
      if (vt[i].wr) chk($sformatf("v%0d_data_o", i), DATA_O, vt[i].wdata);
      chk($sformatf("v%0d_idle_bus", i), 32'({_BR, _BGACK_O, _DMAEN, BUS_OE}), 32'(4'b1110));
    end

    // Burst: REQ held with LAST low until BURST_MAX beats, then re-arbitration.
    cfg_gdelay = 1; cfg_term = T_STERM; cfg_wait = 0; DATA_IN = 32'h0000BEE0;
    for (int i = 0; i < BURST_MAX; i++) sb.push_back('{1'b0, 32'h0000BEE0});
    REQ = 1'b1; LAST = 1'b0; WR = 1'b0;
    cyc = 0; nack = 0; last_ack = 0; owned = 0; rel = 0;
    while (!rel && cyc < 300) begin
      @(negedge SCLK); cyc++;
      if (BUS_OE) owned = 1; else if (owned) rel = 1;
      if (ACK) begin
        if (nack == 0) begin
          chk("burst_dmaen_low", 32'(_DMAEN), 32'd0);
          cfg_gdelay = 50;
        end else chk($sformatf("burst_gap%0d", nack), cyc - last_ack, 4);
        last_ack = cyc; nack++;
      end
    end
    chk("burst_released", 32'(rel), 32'd1);
    chk("burst_ack_count", nack, BURST_MAX);
    chk("burst_bgack_high", 32'(_BGACK_O), 32'd1);
    saw_br = 0; n = 0;
    while (!saw_br && n < 5) begin @(negedge SCLK); n++; if (!_BR) saw_br = 1; end
    chk("burst_rearbitrate", 32'(saw_br), 32'd1);
    REQ = 1'b0;
    repeat (2) @(negedge SCLK);
    chk("req_drop_in_arb_br", 32'(_BR), 32'd1);

    // Grant with another master still driving _AS must not be taken.
    cfg_gdelay = 1; cfg_term = T_STERM; cfg_wait = 0; DATA_IN = 32'h5A5A5A5A;
    as_busy = 1'b1;
    sb.push_back('{1'b0, 32'h5A5A5A5A});
    REQ = 1'b1; LAST = 1'b1;
    repeat (6) @(negedge SCLK);
    chk("as_busy_no_bgack", 32'({_BR, _BGACK_O}), 32'(2'b01));
    as_busy = 1'b0;
    wait_resp("as_busy_resp_seen");
    REQ = 1'b0;
    wait_rel(n);
    chk("as_busy_release", n, 2);

    // Reset in the middle of a WAIT: everything back to reset values, no response.
    cfg_term = T_NONE; REQ = 1'b1; LAST = 1'b1;
    n = 0;
    while (_AS_O && n < 50) begin @(negedge SCLK); n++; end
    chk("rst_beat_started", 32'(_AS_O), 32'd0);
    repeat (2) @(negedge SCLK);
    RST = 1'b1; REQ = 1'b0;
    @(negedge SCLK);
    chk_reset("rst_in_wait");
    RST = 1'b0;
    repeat (5) @(negedge SCLK);
    chk("rst_stays_idle", 32'({_BR, BUS_OE, ACK, ERR}), 32'(4'b1000));

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
